// File: rtl/seq_adder_nbit_pkg.sv
// Shared types and helpers for the multi-cycle chunked adder.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } adder_state_t;

  // Index/counter width for n items, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_adder_nbit_if.sv
// Request/result bundle between a requester and seq_adder_nbit.
interface seq_adder_nbit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, carry_in,
    input  sum, carry_out, overflow, busy, done
  );

  modport slave (
    input  start, a, b, carry_in,
    output sum, carry_out, overflow, busy, done
  );
endinterface

// File: rtl/seq_adder_nbit_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB.
module adder_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_adder_nbit.sv
// Multi-cycle N-bit adder: a + b + carry_in, CHUNK bits per clock, LSB chunk first.
module seq_adder_nbit
  import seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_adder_nbit_if.slave  bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = cnt_width(NCHUNK);
  localparam int unsigned IDX_W  = cnt_width(WIDTH);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_adder_nbit: WIDTH must be >= 1 and a multiple of CHUNK");
  end

  adder_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             accept_c;
  logic [IDX_W-1:0] base_c;
  logic [CHUNK-1:0] ch_s;
  logic             ch_cout, ch_cmsb;

  assign accept_c = bus.start && (state_q != ADD);
  assign base_c   = IDX_W'(cnt_q) * IDX_W'(CHUNK);

  // Single chunk adder shared across all chunk positions.
  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (opa_q[base_c +: CHUNK]),
    .b     (opb_q[base_c +: CHUNK]),
    .cin   (carry_q),
    .s     (ch_s),
    .cout  (ch_cout),
    .c_msb (ch_cmsb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ADD: begin
        sum_d[base_c +: CHUNK] = ch_s;
        carry_d                = ch_cout;
        cnt_d                  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NCHUNK - 1)) begin
          cout_d  = ch_cout;
          ovf_d   = ch_cout ^ ch_cmsb;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = state_q;
    endcase

    // Accepted start overrides the DONE->IDLE step so back-to-back ops have no bubble.
    if (accept_c) begin
      opa_d   = bus.a;
      opb_d   = bus.b;
      carry_d = bus.carry_in;
      cnt_d   = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
      state_d = ADD;
    end
  end

  assign busy_d = (state_d == ADD);
  assign done_d = (state_d == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  always @(posedge clk) begin
    if (!rst && accept_c) begin
      assert (!$isunknown({bus.a, bus.b, bus.carry_in}))
        else $error("seq_adder_nbit: X/Z on operands at accepted start");
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(busy_q && done_q))
    else $error("seq_adder_nbit: busy and done high together");

endmodule

// File: tb/tb_seq_adder_nbit.sv
// Self-checking bench for seq_adder_nbit: CHUNK=4 main instance plus CHUNK=1/16 sweep instances.
module tb_seq_adder_nbit;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_adder_nbit_if #(.WIDTH(W)) ifm ();
  seq_adder_nbit_if #(.WIDTH(W)) if1 ();
  seq_adder_nbit_if #(.WIDTH(W)) if16 ();

  seq_adder_nbit #(.WIDTH(W), .CHUNK(4))  u_main (.clk(clk), .rst(rst), .bus(ifm.slave));
  seq_adder_nbit #(.WIDTH(W), .CHUNK(1))  u_c1   (.clk(clk), .rst(rst), .bus(if1.slave));
  seq_adder_nbit #(.WIDTH(W), .CHUNK(16)) u_c16  (.clk(clk), .rst(rst), .bus(if16.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {overflow, carry_out, sum} from plain integer arithmetic.
  function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin);
    int unsigned u;
    int          s;
    u = 32'(a) + 32'(b) + 32'(cin);
    s = int'($signed(a)) + int'($signed(b)) + int'(cin);
    return {(s > 32767 || s < -32768), u[16], u[15:0]};
  endfunction

  // Transaction-level model of the CHUNK=4 instance: remaining busy cycles plus pending result.
  int          rem   = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_sum  = '0;
  logic        m_co   = 1'b0;
  logic        m_ov   = 1'b0;
  logic [17:0] pend   = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem = 0; m_done = 1'b0; m_sum = '0; m_co = 1'b0; m_ov = 1'b0;
    end else begin
      m_done = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          m_done = 1'b1;
          {m_ov, m_co, m_sum} = pend;
        end
      end else if (ifm.start) begin
        pend = ref_add(ifm.a, ifm.b, ifm.carry_in);
        rem  = 4;
        m_sum = '0; m_co = 1'b0; m_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_busy", 32'(ifm.busy), 32'(rem > 0));
      chk("cyc_done", 32'(ifm.done), 32'(m_done));
      if (rem == 0) begin
        chk("cyc_sum",  32'(ifm.sum),       32'(m_sum));
        chk("cyc_cout", 32'(ifm.carry_out), 32'(m_co));
        chk("cyc_ovf",  32'(ifm.overflow),  32'(m_ov));
      end
    end
  end

  task automatic go(input logic [15:0] a, input logic [15:0] b, input logic cin);
    @(negedge clk);
    ifm.a = a; ifm.b = b; ifm.carry_in = cin; ifm.start = 1'b1;
    @(negedge clk);
    ifm.start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < 40 && !ifm.done; i++) begin
      if (ifm.busy) busy_cnt++;
      @(negedge clk);
    end
    if (!ifm.done) begin
      total++; bad++;
      $display("FAIL %s: done never seen, got busy_cnt=%0d", name, busy_cnt);
    end
  endtask

  task automatic chk_res(input string name, input logic [15:0] s, input logic co, input logic ov);
    chk({name, "_sum"},  32'(ifm.sum),       32'(s));
    chk({name, "_cout"}, 32'(ifm.carry_out), 32'(co));
    chk({name, "_ovf"},  32'(ifm.overflow),  32'(ov));
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_sum"},  32'(ifm.sum),       32'h0);
    chk({name, "_cout"}, 32'(ifm.carry_out), 32'h0);
    chk({name, "_ovf"},  32'(ifm.overflow),  32'h0);
    chk({name, "_busy"}, 32'(ifm.busy),      32'h0);
    chk({name, "_done"}, 32'(ifm.done),      32'h0);
  endtask

  initial begin
    int          n;
    int          lat1, lat16;
    logic [15:0] ra, rb;
    logic        rc;
    logic [17:0] exp;

    ifm.start = 1'b0; ifm.a = '0; ifm.b = '0; ifm.carry_in = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.carry_in = 1'b0;
    if16.start = 1'b0; if16.a = '0; if16.b = '0; if16.carry_in = 1'b0;

    chk("pin_model_ovf",   32'(ref_add(16'h7FFF, 16'h0000, 1'b1)), 32'h28000);
    chk("pin_model_carry", 32'(ref_add(16'hFFFF, 16'h0001, 1'b0)), 32'h10000);

    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    go(16'h1234, 16'h4321, 1'b0);
    wait_done("basic", n);
    chk("basic_busy_cycles", 32'(n), 32'd4);
    chk_res("basic", 16'h5555, 1'b0, 1'b0);

    go(16'hFFFF, 16'h0001, 1'b0);
    wait_done("carry", n);
    chk_res("carry", 16'h0000, 1'b1, 1'b0);

    go(16'h7FFF, 16'h0000, 1'b1);
    wait_done("ovf", n);
    chk_res("ovf", 16'h8000, 1'b0, 1'b1);

    // Start held high with changing operands while busy, dropped before the done cycle.
    @(negedge clk);
    ifm.a = 16'h1111; ifm.b = 16'h2222; ifm.carry_in = 1'b0; ifm.start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      ifm.a = 16'($urandom); ifm.b = 16'($urandom); ifm.carry_in = 1'b1;
      @(negedge clk);
    end
    ifm.start = 1'b0;
    wait_done("hold", n);
    chk_res("hold", 16'h3333, 1'b0, 1'b0);
    ifm.a = 16'h0F0F; ifm.b = 16'h0101; ifm.carry_in = 1'b0; ifm.start = 1'b1;
    @(negedge clk);
    ifm.start = 1'b0;
    chk("b2b_busy_after_done", 32'(ifm.busy), 32'h1);
    wait_done("b2b", n);
    chk("b2b_busy_cycles", 32'(n), 32'd4);
    chk_res("b2b", 16'h1010, 1'b0, 1'b0);

    // Asynchronous abort in the second ADD cycle.
    go(16'h1111, 16'h1111, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    go(16'h0003, 16'h0004, 1'b0);
    wait_done("after_abort", n);
    chk("after_abort_busy_cycles", 32'(n), 32'd4);
    chk_res("after_abort", 16'h0007, 1'b0, 1'b0);

    // CHUNK=1 and CHUNK=16 run the same random vectors side by side.
    for (int v = 0; v < 1000; v++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
      exp = ref_add(ra, rb, rc);
      @(negedge clk);
      if1.a = ra;  if1.b = rb;  if1.carry_in = rc;  if1.start = 1'b1;
      if16.a = ra; if16.b = rb; if16.carry_in = rc; if16.start = 1'b1;
      lat1 = -1; lat16 = -1;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (i == 1) begin
          if1.start = 1'b0; if16.start = 1'b0;
        end
        if (if1.done && lat1 < 0) begin
          lat1 = i - 1;
          chk("c1_result", 32'({if1.overflow, if1.carry_out, if1.sum}), 32'(exp));
        end
        if (if16.done && lat16 < 0) begin
          lat16 = i - 1;
          chk("c16_result", 32'({if16.overflow, if16.carry_out, if16.sum}), 32'(exp));
        end
        if (lat1 >= 0 && lat16 >= 0) break;
      end
      chk("c1_latency",  32'(lat1),  32'd16);
      chk("c16_latency", 32'(lat16), 32'd1);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
